// File: rtl/melody_scheduler.sv
// Melody scheduler: steps one square-wave tone through a per-song note table and
// hands one signed sample to the codec per transfer. Build option: MELODY_SCHEDULER_LOOP_EN repeats the song.
module melody_scheduler #(
    parameter int unsigned BEAT_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES  = 2500000,
    parameter int          AMPLITUDE   = 10000000,
    parameter int unsigned HALF_SHIFT  = 0,
    parameter int unsigned SONG_LEN    = 16
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic        start,
    input  logic        stop,
    input  logic        song_sel,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [31:0] sample,
    output logic        busy,
    output logic [2:0]  note_code,
    output logic [3:0]  note_index,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_END
    } state_e;

    state_e             state_q, state_d;
    logic               song_q, song_d;
    logic [3:0]         index_q, index_d;
    logic [2:0]         note_q, note_d;
    logic [39:0]        cnt_q, cnt_d;
    logic [17:0]        tone_q, tone_d;
    logic               pol_q, pol_d;
    logic               valid_q;
    logic signed [31:0] sample_q;
    logic signed [31:0] level;
    logic [5:0]         entry;
    logic [17:0]        half;

    // Table entry = {note, beats}; a zero beat count terminates the song.
    function automatic logic [5:0] rom(input logic song, input logic [3:0] idx);
        logic [5:0] e;
        e = 6'd0;
        if (!song) begin
            case (idx)
                4'd0:    e = {3'd1, 3'd2};
                4'd1:    e = {3'd5, 3'd2};
                4'd2:    e = {3'd6, 3'd2};
                4'd3:    e = {3'd5, 3'd1};
                4'd4:    e = {3'd4, 3'd2};
                4'd5:    e = {3'd3, 3'd2};
                4'd6:    e = {3'd2, 3'd2};
                4'd7:    e = {3'd1, 3'd2};
                default: e = 6'd0;
            endcase
        end else begin
            case (idx)
                4'd0:    e = {3'd3, 3'd1};
                4'd1:    e = {3'd2, 3'd1};
                4'd2:    e = {3'd1, 3'd1};
                4'd3:    e = {3'd5, 3'd1};
                4'd4:    e = {3'd4, 3'd1};
                4'd5:    e = {3'd3, 3'd1};
                4'd6:    e = {3'd2, 3'd3};
                4'd7:    e = {3'd1, 3'd4};
                default: e = 6'd0;
            endcase
        end
        return e;
    endfunction

    function automatic logic [17:0] half_of(input logic [2:0] n);
        logic [17:0] h;
        case (n)
            3'd1:    h = 18'd191113;
            3'd2:    h = 18'd170262;
            3'd3:    h = 18'd151686;
            3'd4:    h = 18'd143173;
            3'd5:    h = 18'd127553;
            3'd6:    h = 18'd113636;
            3'd7:    h = 18'd101238;
            default: h = 18'd0;
        endcase
        return h >> HALF_SHIFT;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        index_d = index_q;
        note_d  = note_q;
        cnt_d   = cnt_q;
        tone_d  = tone_q;
        pol_d   = pol_q;
        entry   = rom(song_q, index_q);
        half    = half_of(note_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    song_d  = song_sel;
                    index_d = '0;
                end
            end
            S_FETCH: begin
                note_d  = entry[5:3];
                tone_d  = '0;
                pol_d   = 1'b1;
                cnt_d   = 40'(entry[2:0]) * 40'(BEAT_CYCLES) - 40'd1;
                state_d = (entry[2:0] == 3'd0) ? S_END : S_PLAY;
            end
            S_PLAY: begin
                // Polarity holds for half+1 cycles before flipping.
                if (tone_q == half) begin
                    tone_d = '0;
                    pol_d  = ~pol_q;
                end else begin
                    tone_d = tone_q + 18'd1;
                end
                if (cnt_q == 40'd0) begin
                    state_d = S_GAP;
                    cnt_d   = 40'(GAP_CYCLES) - 40'd1;
                end else begin
                    cnt_d = cnt_q - 40'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 40'd0) begin
                    if (index_q == 4'(SONG_LEN - 1)) begin
                        state_d = S_END;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - 40'd1;
                end
            end
            S_END: begin
                index_d = '0;
                note_d  = '0;
`ifdef MELODY_SCHEDULER_LOOP_EN
                state_d = S_FETCH;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Stop overrides everything, including a simultaneous start.
        if (stop) begin
            state_d = S_IDLE;
            index_d = '0;
            note_d  = '0;
        end
    end

    always_comb begin
        level = '0;
        if (state_q == S_PLAY && note_q != 3'd0) begin
            level = pol_q ? AMPLITUDE : -AMPLITUDE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            song_q   <= 1'b0;
            index_q  <= '0;
            note_q   <= '0;
            cnt_q    <= '0;
            tone_q   <= '0;
            pol_q    <= 1'b1;
            valid_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            index_q <= index_d;
            note_q  <= note_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            pol_q   <= pol_d;
            valid_q <= 1'b1;
            // The sample only moves after the codec has taken the previous one.
            if (valid_q && sample_ready) begin
                sample_q <= level;
            end
        end
    end

    assign sample_valid = valid_q;
    assign sample       = sample_q;
    assign busy         = (state_q != S_IDLE);
    assign note_code    = note_q;
    assign note_index   = index_q;
    assign done         = (state_q == S_END);

endmodule

// File: tb/tb_melody_scheduler.sv
// Testbench for melody_scheduler: per-cycle expectations generated from the note tables,
// samples checked through a transfer scoreboard. Honours MELODY_SCHEDULER_LOOP_EN.
module tb_melody_scheduler;

    localparam int BEAT  = 100;
    localparam int GAP   = 10;
    localparam int SHIFT = 10;
    localparam int AMP   = 10000000;
    localparam int LEN   = 16;
`ifdef MELODY_SCHEDULER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        song_sel = 1'b0;
    logic        sample_ready = 1'b0;
    logic        sample_valid;
    logic [31:0] sample;
    logic        busy;
    logic [2:0]  note_code;
    logic [3:0]  note_index;
    logic        done;

    melody_scheduler #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .AMPLITUDE  (AMP),
        .HALF_SHIFT (SHIFT),
        .SONG_LEN   (LEN)
    ) dut (
        .CLOCK_50    (clk),
        .Reset       (rst_n),
        .start       (start),
        .stop        (stop),
        .song_sel    (song_sel),
        .sample_ready(sample_ready),
        .sample_valid(sample_valid),
        .sample      (sample),
        .busy        (busy),
        .note_code   (note_code),
        .note_index  (note_index),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int level;
        bit busy;
        bit done;
        int note;
        int idx;
    } exp_t;

    exp_t trace[$];
    int   sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   exp_hold = 0;
    bit   cur_sel = 1'b0;

    int tw_note[8]  = '{1, 5, 6, 5, 4, 3, 2, 1};
    int tw_beat[8]  = '{2, 2, 2, 1, 2, 2, 2, 2};
    int hc_note[8]  = '{3, 2, 1, 5, 4, 3, 2, 1};
    int hc_beat[8]  = '{1, 1, 1, 1, 1, 1, 3, 4};
    int half_tab[8] = '{0, 191113, 170262, 151686, 143173, 127553, 113636, 101238};

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input int lv, input bit b, input bit d, input int n, input int i);
        exp_t e;
        e.level = lv;
        e.busy  = b;
        e.done  = d;
        e.note  = n;
        e.idx   = i;
        trace.push_back(e);
    endtask

    // Whole-song timeline: fetch, square wave for beats*BEAT cycles, gap; then end fetch and done.
    task automatic append_song(input bit sel);
        int prev;
        int n;
        int b;
        int h;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            n = sel ? hc_note[i] : tw_note[i];
            b = sel ? hc_beat[i] : tw_beat[i];
            h = (half_tab[n] >> SHIFT) + 1;
            push_exp(0, 1'b1, 1'b0, prev, i);
            for (int k = 0; k < b * BEAT; k++)
                push_exp(((k / h) % 2 == 0) ? AMP : -AMP, 1'b1, 1'b0, n, i);
            for (int g = 0; g < GAP; g++)
                push_exp(0, 1'b1, 1'b0, n, i);
            prev = n;
        end
        push_exp(0, 1'b1, 1'b0, prev, 8);
        push_exp(0, 1'b1, 1'b1, 0, 8);
    endtask

    function automatic int song_latency(input bit sel);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += sel ? hc_beat[i] : tw_beat[i];
        return s * BEAT + 8 * GAP + 10;
    endfunction

    // One clock: check state of the current cycle, drive inputs, queue the transferred level.
    task automatic cycle(input bit st, input bit sp, input bit sel, input bit rdy);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (trace.size() > 0) e = trace.pop_front();
        else begin
            e.level = 0; e.busy = 1'b0; e.done = 1'b0; e.note = 0; e.idx = 0;
        end
        check("busy", longint'(busy), longint'(e.busy));
        check("done", longint'(done), longint'(e.done));
        check("note_code", longint'(note_code), longint'(e.note));
        check("note_index", longint'(note_index), longint'(e.idx));
        check("sample_valid", longint'(sample_valid), 1);
        if (e.done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        start        = st;
        stop         = sp;
        song_sel     = sel;
        sample_ready = rdy;
        if (rdy) sb.push_back(e.level);
        if (sp) trace.delete();
        else if (e.done && LOOP_EN) append_song(cur_sel);
        else if (st && !e.busy) begin
            cur_sel = sel;
            append_song(sel);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
        trace.delete();
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", longint'(busy), 0);
            check("rst_done", longint'(done), 0);
            check("rst_valid", longint'(sample_valid), 0);
            check("rst_note", longint'(note_code), 0);
            check("rst_index", longint'(note_index), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_done(input int c_start, input int seen0, input bit sel,
                             input int rdy_pct, input bit noise);
        for (int n = 0; n < 4000 && done_cnt == seen0; n++)
            cycle(noise && ($urandom_range(0, 63) == 0), 1'b0,
                  noise ? 1'($urandom_range(0, 1)) : sel,
                  $urandom_range(0, 99) < rdy_pct);
        check("done_pulses", done_cnt - seen0, 1);
        check("done_latency", last_done_cyc - c_start, song_latency(sel));
        if (LOOP_EN) begin
            repeat (300) cycle(1'b0, 1'b0, sel, 1'b1);
            cycle(1'b0, 1'b1, sel, 1'b1);
        end
        repeat (5) cycle(1'b0, 1'b0, sel, 1'b1);
    endtask

    task automatic play_song(input bit sel, input int rdy_pct, input bit noise);
        int c0;
        int seen0;
        seen0 = done_cnt;
        cycle(1'b1, 1'b0, sel, 1'b1);
        c0 = cyc;
        wait_done(c0, seen0, sel, rdy_pct, noise);
    endtask

    // Sample scoreboard: each queued level is the value the DUT must show after that transfer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_hold = 0;
                check("sample_in_reset", longint'($signed(sample)), 0);
            end else if (sb.size() > 0) begin
                exp_hold = sb.pop_front();
                check("sample", longint'($signed(sample)), longint'(exp_hold));
            end else begin
                check("sample_hold", longint'($signed(sample)), longint'(exp_hold));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int seen0;

        do_reset();
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Hot cross buns with random ready, spurious starts and song_sel noise.
        play_song(1'b1, 80, 1'b1);
        // Twinkle, clean handshake.
        play_song(1'b0, 100, 1'b0);

        // Stop in the middle of note index 3.
        seen0 = done_cnt;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (659) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("stop_at_index", longint'(note_index), 3);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("no_done_after_stop", done_cnt - seen0, 0);

        // Codec stalls for 300 cycles in the middle of a note.
        seen0 = done_cnt;
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        c0 = cyc;
        repeat (50) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (300) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(c0, seen0, 1'b0, 100, 1'b0);

        // Simultaneous start and stop from idle: stop wins.
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a song.
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (400) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        seen0 = done_cnt;
        do_reset();
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("no_done_after_reset", done_cnt - seen0, 0);

        // Free-running random traffic.
        repeat (3000)
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) < 80);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
